led_frame_loader: RTL and testbench

LED_FRAME_LOADER -- requirements
Module: led_frame_loader

---
 rtl/led_frame_loader_if.sv | 24 ++
 rtl/led_frame_loader.sv | 159 +++++++++++++++
 tb/tb_led_frame_loader.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/led_frame_loader_if.sv
// SPI input and frame-output bundle for the LED frame loader.
// The master side drives the SPI lines and observes the committed frame and
// status strobes. The slave side is the loader itself.
interface led_frame_loader_if #(
  parameter int W = 72
);
  logic         spi_sclk;
  logic         spi_mosi;
  logic         spi_cs_n;
  logic [W-1:0] data_o;
  logic         busy;
  logic         frame_done;
  logic         frame_err;

  modport master (
    output spi_sclk, spi_mosi, spi_cs_n,
    input  data_o, busy, frame_done, frame_err
  );

  modport slave (
    input  spi_sclk, spi_mosi, spi_cs_n,
    output data_o, busy, frame_done, frame_err
  );
endinterface

// File: rtl/led_frame_loader.sv
// LED frame loader: receives one W-bit frame over mode-0 SPI, MSB first, into
// a shadow register. It commits the frame to data_o atomically only when
// exactly W bits were clocked between cs_n falling and cs_n rising.
module led_frame_loader #(
  parameter int LED_CNT       = 3,
  parameter int CHANNELS      = 3,
  parameter int BITPERCHANNEL = 8
) (
  input  logic             clk,
  input  logic             reset,
  led_frame_loader_if.slave bus
);

  localparam int W     = LED_CNT * CHANNELS * BITPERCHANNEL;
  localparam int CNT_W = $clog2(W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(W);

  typedef enum logic {IDLE, SHIFT} state_t;

  // Synchroniser stages: _p0 and _p1 form the 2-flop synchroniser, _p2 is history.
  logic cs_n_p0, cs_n_p1, cs_n_p2;
  logic sclk_p0, sclk_p1, sclk_p2;
  logic mosi_p0, mosi_p1, mosi_p2;

  // vld_pN marks that synchroniser stage N holds a post-reset sample of the pins.
  logic vld_p0, vld_p1;
  logic armed;

  state_t state_q, state_d;

  logic [W-1:0]     shadow_q, shadow_d;
  logic [W-1:0]     data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic cs_fall, cs_rise, sclk_rise;

  // Bring the asynchronous SPI pins into the clk domain and keep one history sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_n_p0 <= 1'b1;
      cs_n_p1 <= 1'b1;
      cs_n_p2 <= 1'b1;
      sclk_p0 <= 1'b0;
      sclk_p1 <= 1'b0;
      sclk_p2 <= 1'b0;
      mosi_p0 <= 1'b0;
      mosi_p1 <= 1'b0;
      mosi_p2 <= 1'b0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      cs_n_p0 <= bus.spi_cs_n;
      cs_n_p1 <= cs_n_p0;
      cs_n_p2 <= cs_n_p1;
      sclk_p0 <= bus.spi_sclk;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
      mosi_p0 <= bus.spi_mosi;
      mosi_p1 <= mosi_p0;
      mosi_p2 <= mosi_p1;
      vld_p0  <= 1'b1;
      vld_p1  <= vld_p0;
    end
  end

  // Only accept a cs_n fall once a real high level of cs_n has been seen since
  // reset; the reset value of the cs_n flops is 1, so a pin held low through
  // reset would otherwise look like a frame start.
  always_ff @(posedge clk) begin
    if (reset) begin
      armed <= 1'b0;
    end else if (vld_p1 && cs_n_p1) begin
      armed <= 1'b1;
    end
  end

  // Edge detection compares synchroniser stage 2 against the history flop.
  // mosi is taken from the history flop: the sample taken just before sclk
  // was seen rising, when mode-0 data is guaranteed stable.
  assign cs_fall   = armed & cs_n_p2 & ~cs_n_p1;
  assign cs_rise   = ~cs_n_p2 & cs_n_p1;
  assign sclk_rise = ~sclk_p2 & sclk_p1;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, shifting, and commit/reject decision; cs_n rise outranks sclk rise.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = IDLE;
          if ((cnt_q == CNT_FULL) && !ovf_q) begin
            data_d = shadow_q;
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (sclk_rise) begin
          if (cnt_q == CNT_FULL) begin
            ovf_d = 1'b1;
          end else begin
            shadow_d = {shadow_q[W-2:0], mosi_p2};
            cnt_d    = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame datapath and status strobes; reset discards any partial frame silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.data_o     = data_q;
  assign bus.busy       = (state_q == SHIFT);
  assign bus.frame_done = done_q;
  assign bus.frame_err  = err_q;

endmodule

// File: tb/tb_led_frame_loader.sv
// Directed bench for led_frame_loader: SPI frames at clk/8, commit latency,
// short/long frame rejection, reset mid-frame and with cs_n low, back-to-back
// frames and a simultaneous sclk/cs_n edge.
module tb_led_frame_loader;

  localparam int W = 72;

  logic clk;
  logic reset;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  led_frame_loader_if #(.W(W)) bus ();

  led_frame_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.frame_done) done_cnt++;
    if (bus.frame_err) err_cnt++;
    if (bus.frame_done && bus.frame_err) both_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Send the low n bits of v, MSB first, one bit per 8 clk periods.
  task automatic send_bits(input logic [79:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus.spi_mosi = v[i];
      repeat (4) @(negedge clk);
      bus.spi_sclk = 1'b1;
      repeat (4) @(negedge clk);
      bus.spi_sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [79:0] v, input int n, input int gap);
    bus.spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(v, n);
    repeat (2) @(negedge clk);
    bus.spi_cs_n = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  localparam logic [79:0] F1   = 80'h00FF000000FF000000FF;
  localparam logic [79:0] V71  = 80'h000055AA55AA55AA55AA;
  localparam logic [79:0] V73  = 80'h015A5A5A5A5A5A5A5A5A;
  localparam logic [79:0] FA   = 80'h00123456789ABCDEF012;
  localparam logic [79:0] FB   = 80'h00FFFFFFFFFFFFFFFFFF;
  localparam logic [79:0] FC   = 80'h00C3C3C3C3C3C3C3C3C3;
  localparam logic [79:0] FD   = 80'h000F0F0F0F0F0F0F0F0F;
  localparam logic [79:0] FE   = 80'h000123456789ABCDEF01;
  localparam logic [79:0] FG   = 80'h00A5A5A5A5A5A5A5A5A5;

  initial begin
    reset        = 1'b1;
    bus.spi_cs_n = 1'b1;
    bus.spi_sclk = 1'b0;
    bus.spi_mosi = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", bus.data_o, 80'h0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.frame_done, 1'b0);
    check("rst_err", bus.frame_err, 1'b0);
    reset = 1'b0;
    repeat (6) @(negedge clk);

    // Full 72-bit frame with exact commit latency.
    bus.spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(F1 >> 36, 36);
    check("busy_mid", bus.busy, 1'b1);
    send_bits(F1, 36);
    repeat (2) @(negedge clk);
    check("data_before_commit", bus.data_o, 80'h0);
    bus.spi_cs_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("done_e2", bus.frame_done, 1'b0);
    check("data_e2", bus.data_o, 80'h0);
    @(posedge clk);
    #1;
    check("done_e3", bus.frame_done, 1'b1);
    check("err_e3", bus.frame_err, 1'b0);
    check("data_e3", bus.data_o, F1);
    @(posedge clk);
    #1;
    check("done_e4", bus.frame_done, 1'b0);
    check("busy_after", bus.busy, 1'b0);
    repeat (4) @(negedge clk);
    check("done_cnt_f1", done_cnt, 1);

    // Short then long frame: rejected, data held.
    send_frame(V71, 71, 8);
    check("err_cnt_71", err_cnt, 1);
    check("data_71", bus.data_o, F1);
    send_frame(V73, 73, 8);
    check("err_cnt_73", err_cnt, 2);
    check("data_73", bus.data_o, F1);
    check("done_cnt_bad", done_cnt, 1);

    // Back-to-back frames with a 4-clk cs_n high gap.
    send_frame(FA, 72, 4);
    check("data_A", bus.data_o, FA);
    send_frame(FB, 72, 8);
    check("data_B", bus.data_o, FB);
    check("done_cnt_AB", done_cnt, 3);

    // Reset after 40 bits of a frame.
    bus.spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(FD, 40);
    reset = 1'b1;
    @(negedge clk);
    bus.spi_cs_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst2_data", bus.data_o, 80'h0);
    check("rst2_busy", bus.busy, 1'b0);
    check("rst2_done", bus.frame_done, 1'b0);
    check("rst2_err", bus.frame_err, 1'b0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("rst2_err_cnt", err_cnt, 2);
    send_frame(FC, 72, 8);
    check("data_C", bus.data_o, FC);
    check("done_cnt_C", done_cnt, 4);

    // Reset released with cs_n held low, then 72 clocks.
    bus.spi_cs_n = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(FD, 72);
    repeat (4) @(negedge clk);
    check("csl_busy", bus.busy, 1'b0);
    bus.spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
    check("csl_data", bus.data_o, 80'h0);
    check("csl_done_cnt", done_cnt, 4);
    check("csl_err_cnt", err_cnt, 2);
    send_frame(FE, 72, 8);
    check("data_E", bus.data_o, FE);
    check("done_cnt_E", done_cnt, 5);

    // sclk rise coincident with cs_n rise after 72 bits.
    bus.spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(FG, 72);
    repeat (2) @(negedge clk);
    bus.spi_sclk = 1'b1;
    bus.spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
    bus.spi_sclk = 1'b0;
    repeat (4) @(negedge clk);
    check("data_G", bus.data_o, FG);
    check("done_cnt_G", done_cnt, 6);
    check("err_cnt_G", err_cnt, 2);
    check("busy_G", bus.busy, 1'b0);

    check("done_err_overlap", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
